log_mac_accumulator: RTL and testbench

//  Downstream consumer of the approximate log multiplier's registered 16-bit signed product.

---
 rtl/log_mac_accumulator.sv | 112 +++++++++++
 tb/tb_log_mac_accumulator.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/log_mac_accumulator.sv
// ============================================================================
// Module      : log_mac_accumulator
// Description : Saturating dot-product accumulator for a signed product stream,
//               with a valid/ready result register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module log_mac_accumulator #(
  parameter int PROD_W  = 16,
  parameter int ACC_W   = 24,
  parameter int MAX_LEN = 64,
  localparam int CNT_W  = $clog2(MAX_LEN + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     prod_valid,
  output logic                     prod_ready,
  input  logic signed [PROD_W-1:0] prod,
  input  logic                     prod_last,
  input  logic                     flush,
  output logic                     acc_valid,
  input  logic                     acc_ready,
  output logic signed [ACC_W-1:0]  acc_data,
  output logic [CNT_W-1:0]         acc_count,
  output logic                     acc_ovf,
  output logic                     acc_trunc
);

  localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(MAX_LEN - 1);
  localparam logic [ACC_W-1:0] c_pos_max  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] c_neg_min  = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [ACC_W-1:0] r_sum;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_ovf;
  logic                    r_acc_valid;
  logic signed [ACC_W-1:0] r_acc_data;
  logic [CNT_W-1:0]        r_acc_count;
  logic                    r_acc_ovf;
  logic                    r_acc_trunc;

  logic                    w_accept;
  logic [ACC_W:0]          w_sum_wide;
  logic                    w_sat;
  logic [ACC_W-1:0]        w_sum_sat;
  logic [CNT_W-1:0]        w_cnt_n;
  logic                    w_ovf_n;
  logic                    w_at_cap;
  logic                    w_trunc;
  logic                    w_close;

  // Reset gating keeps every output at zero while rst is held.
  assign prod_ready = ~rst & (~r_acc_valid | acc_ready);
  assign w_accept   = prod_valid & prod_ready;

  // One guard bit above ACC_W: the top two bits disagree exactly on overflow.
  assign w_sum_wide = {r_sum[ACC_W-1], r_sum}
                    + {{(ACC_W + 1 - PROD_W){prod[PROD_W-1]}}, prod};
  assign w_sat      = w_sum_wide[ACC_W] ^ w_sum_wide[ACC_W-1];
  assign w_sum_sat  = !w_sat            ? w_sum_wide[ACC_W-1:0] :
                      w_sum_wide[ACC_W] ? c_neg_min : c_pos_max;

  assign w_cnt_n  = w_accept ? r_cnt + CNT_W'(1) : r_cnt;
  assign w_ovf_n  = r_ovf | (w_accept & w_sat);
  assign w_at_cap = w_accept & (r_cnt == c_last_idx);
  assign w_trunc  = w_at_cap & ~prod_last & ~flush;
  assign w_close  = prod_ready
                  & ((w_accept & (prod_last | w_at_cap))
                     | (flush & (w_accept | (r_cnt != '0))));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_acc_valid <= 1'b0;
      r_acc_data  <= '0;
      r_acc_count <= '0;
      r_acc_ovf   <= 1'b0;
      r_acc_trunc <= 1'b0;
    end else if (w_close) begin
      r_acc_valid <= 1'b1;
      r_acc_data  <= w_accept ? w_sum_sat : r_sum;
      r_acc_count <= w_cnt_n;
      r_acc_ovf   <= w_ovf_n;
      r_acc_trunc <= w_trunc;
      r_sum       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_sum <= w_sum_sat;
        r_cnt <= w_cnt_n;
        r_ovf <= w_ovf_n;
      end
      // Result data registers keep their stale value after being taken.
      if (r_acc_valid & acc_ready) begin
        r_acc_valid <= 1'b0;
      end
    end
  end

  assign acc_valid = r_acc_valid;
  assign acc_data  = r_acc_data;
  assign acc_count = r_acc_count;
  assign acc_ovf   = r_acc_ovf;
  assign acc_trunc = r_acc_trunc;

endmodule

`default_nettype wire

// File: tb/tb_log_mac_accumulator.sv
// ============================================================================
// Module      : tb_log_mac_accumulator
// Description : Randomized and directed bench for log_mac_accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_log_mac_accumulator;

  localparam int PW  = 16;
  localparam int AW  = 18;
  localparam int ML  = 64;
  localparam int CW  = $clog2(ML + 1);
  localparam int BAW = 24;
  localparam int BML = 1024;
  localparam int BCW = $clog2(BML + 1);

  localparam longint MAXV = (longint'(1) << (AW - 1)) - 1;
  localparam longint MINV = -(longint'(1) << (AW - 1));

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, prod_valid, prod_last, flush, acc_ready;
  logic signed [PW-1:0] prod;
  logic                 prod_ready, acc_valid, acc_ovf, acc_trunc;
  logic signed [AW-1:0] acc_data;
  logic [CW-1:0]        acc_count;

  logic                  b_rst, b_prod_valid, b_prod_last, b_flush, b_acc_ready;
  logic signed [PW-1:0]  b_prod;
  logic                  b_prod_ready, b_acc_valid, b_acc_ovf, b_acc_trunc;
  logic signed [BAW-1:0] b_acc_data;
  logic [BCW-1:0]        b_acc_count;

  log_mac_accumulator #(.PROD_W(PW), .ACC_W(AW), .MAX_LEN(ML)) dut (
    .clk(clk), .rst(rst), .prod_valid(prod_valid), .prod_ready(prod_ready),
    .prod(prod), .prod_last(prod_last), .flush(flush), .acc_valid(acc_valid),
    .acc_ready(acc_ready), .acc_data(acc_data), .acc_count(acc_count),
    .acc_ovf(acc_ovf), .acc_trunc(acc_trunc)
  );

  log_mac_accumulator #(.PROD_W(PW), .ACC_W(BAW), .MAX_LEN(BML)) dut_big (
    .clk(clk), .rst(b_rst), .prod_valid(b_prod_valid), .prod_ready(b_prod_ready),
    .prod(b_prod), .prod_last(b_prod_last), .flush(b_flush), .acc_valid(b_acc_valid),
    .acc_ready(b_acc_ready), .acc_data(b_acc_data), .acc_count(b_acc_count),
    .acc_ovf(b_acc_ovf), .acc_trunc(b_acc_trunc)
  );

  // Reference model: open vector as a plain integer sum plus expected result register.
  longint m_sum;
  int     m_cnt;
  bit     m_ovf;
  bit     e_valid, e_zero, e_ovf, e_trunc;
  longint e_data;
  int     e_count;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    bit     rdy, acc, closing;
    longint ns;
    int     nc;
    bit     no;
    #1;
    rdy = !rst && (!e_valid || acc_ready);
    chk("prod_ready", {63'b0, prod_ready}, {63'b0, rdy});
    acc = prod_valid && rdy;
    if (rst) begin
      m_sum = 0; m_cnt = 0; m_ovf = 0;
      e_valid = 0; e_zero = 1; e_data = 0; e_count = 0; e_ovf = 0; e_trunc = 0;
    end else begin
      ns = m_sum; nc = m_cnt; no = m_ovf;
      if (acc) begin
        ns = m_sum + longint'(prod);
        if (ns > MAXV) begin ns = MAXV; no = 1; end
        if (ns < MINV) begin ns = MINV; no = 1; end
        nc = m_cnt + 1;
      end
      closing = rdy && ((acc && (prod_last || nc == ML)) || (flush && nc > 0));
      if (closing) begin
        e_valid = 1; e_zero = 0; e_data = ns; e_count = nc; e_ovf = no;
        e_trunc = (nc == ML) && !prod_last && !flush;
        m_sum = 0; m_cnt = 0; m_ovf = 0;
      end else begin
        if (e_valid && acc_ready) e_valid = 0;
        m_sum = ns; m_cnt = nc; m_ovf = no;
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("acc_valid", {63'b0, acc_valid}, {63'b0, e_valid});
    if (e_valid || e_zero) begin
      chk("acc_data", acc_data, e_data);
      chk("acc_count", {{(64-CW){1'b0}}, acc_count}, e_count);
      chk("acc_ovf", {63'b0, acc_ovf}, {63'b0, e_ovf});
      chk("acc_trunc", {63'b0, acc_trunc}, {63'b0, e_trunc});
    end
  endtask

  task automatic idle();
    prod_valid = 0; prod_last = 0; flush = 0; prod = '0;
    tick();
  endtask

  task automatic beat(input int p, input bit last);
    prod_valid = 1; prod = PW'(p); prod_last = last; flush = 0;
    tick();
    prod_valid = 0; prod_last = 0;
  endtask

  task automatic chk_res(input string nm, input longint d, input int c,
                         input bit o, input bit t);
    chk({nm, "_valid"}, {63'b0, acc_valid}, 64'sd1);
    chk({nm, "_data"}, acc_data, d);
    chk({nm, "_count"}, {{(64-CW){1'b0}}, acc_count}, c);
    chk({nm, "_ovf"}, {63'b0, acc_ovf}, {63'b0, o});
    chk({nm, "_trunc"}, {63'b0, acc_trunc}, {63'b0, t});
  endtask

  initial begin
    rst = 1; prod_valid = 0; prod_last = 0; flush = 0; acc_ready = 1; prod = '0;
    b_rst = 1; b_prod_valid = 0; b_prod_last = 0; b_flush = 0; b_acc_ready = 1; b_prod = '0;
    m_sum = 0; m_cnt = 0; m_ovf = 0;
    e_valid = 0; e_zero = 1; e_data = 0; e_count = 0; e_ovf = 0; e_trunc = 0;

    tick(); tick();
    chk("rst_ready", {63'b0, prod_ready}, 64'sd0);
    chk("rst_valid", {63'b0, acc_valid}, 64'sd0);
    chk("rst_data", acc_data, 64'sd0);
    rst = 0; b_rst = 0;
    idle();

    // T1
    beat(100, 0); beat(-30, 0); beat(5, 1);
    chk_res("t1", 75, 3, 0, 0);
    idle();

    // T3: length cap then flush of the remainder
    for (int i = 0; i < 70; i++) begin
      beat(1, 0);
      if (i == 63) chk_res("t3a", 64, 64, 0, 1);
    end
    prod_valid = 0; flush = 1; tick(); flush = 0;
    chk_res("t3b", 6, 6, 0, 0);
    idle();

    // Saturation on the narrow accumulator, then a clean vector
    for (int i = 0; i < 10; i++) beat(32767, i == 9);
    chk_res("sat", MAXV, 10, 1, 0);
    beat(-1, 1);
    chk_res("sat_next", -1, 1, 0, 0);
    idle();

    // T4: backpressure then release coincident with a last beat
    acc_ready = 0;
    beat(10, 1);
    chk_res("t4a", 10, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      prod_valid = 1; prod = PW'(20); prod_last = 1;
      #1 chk("t4_stall_ready", {63'b0, prod_ready}, 64'sd0);
      tick();
      chk_res("t4_hold", 10, 1, 0, 0);
    end
    acc_ready = 1;
    tick();
    chk_res("t4b", 20, 1, 0, 0);
    idle();
    idle();

    // T5
    flush = 1; tick(); flush = 0;
    chk("t5_noflush", {63'b0, acc_valid}, 64'sd0);
    prod_valid = 1; prod = PW'(-7); prod_last = 0; flush = 1;
    tick();
    flush = 0; prod_valid = 0;
    chk_res("t5", -7, 1, 0, 0);
    idle();

    // T6: reset mid-vector
    beat(5, 0); beat(5, 0); beat(5, 0);
    rst = 1; tick();
    chk("t6_rst_ready", {63'b0, prod_ready}, 64'sd0);
    chk("t6_rst_valid", {63'b0, acc_valid}, 64'sd0);
    chk("t6_rst_data", acc_data, 64'sd0);
    rst = 0;
    beat(2, 0); beat(2, 1);
    chk_res("t6", 4, 2, 0, 0);
    idle();

    // T2 on the wide / long instance
    for (int i = 0; i < 600; i++) begin
      b_prod_valid = 1; b_prod = 16'sd32767; b_prod_last = (i == 599);
      idle();
    end
    b_prod_valid = 0; b_prod_last = 0;
    chk("t2_valid", {63'b0, b_acc_valid}, 64'sd1);
    chk("t2_data", b_acc_data, 64'sd8388607);
    chk("t2_count", {{(64-BCW){1'b0}}, b_acc_count}, 64'sd600);
    chk("t2_ovf", {63'b0, b_acc_ovf}, 64'sd1);
    b_prod_valid = 1; b_prod = -16'sd1; b_prod_last = 1;
    idle();
    b_prod_valid = 0; b_prod_last = 0;
    chk("t2b_data", b_acc_data, -64'sd1);
    chk("t2b_ovf", {63'b0, b_acc_ovf}, 64'sd0);
    chk("t2b_count", {{(64-BCW){1'b0}}, b_acc_count}, 64'sd1);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rst        = ($urandom_range(0, 399) == 0);
      prod_valid = ($urandom_range(0, 9) < 7);
      prod       = ($urandom_range(0, 3) == 0) ? PW'($urandom)
                                               : PW'($urandom_range(0, 200)) - PW'(100);
      if ($urandom_range(0, 7) == 0) prod = PW'(32767);
      prod_last  = ($urandom_range(0, 23) == 0);
      flush      = ($urandom_range(0, 29) == 0);
      acc_ready  = ($urandom_range(0, 3) != 0);
      tick();
    end
    rst = 0;
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
